// File: rtl/bytebeat_sample_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bytebeat_sample_mixer_if
//  Brief    : Channel-side and PWM-side handshake bundle of the sample mixer.
//  Revision : 1.0 - initial release
// ============================================================================
interface bytebeat_sample_mixer_if #(
    parameter int N_CH = 8,
    parameter int W    = 8
);
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_vld;
    logic [N_CH-1:0]   ch_rdy;
    logic [N_CH-1:0]   ch_mask;
    logic [W-1:0]      mix_out;
    logic              mix_vld;
    logic              mix_rdy;
    logic              ovr_clr;
    logic              overrun;

    // master: generators + PWM stage side; slave: the mixer itself
    modport master (
        output ch_data, ch_vld, ch_mask, mix_rdy, ovr_clr,
        input  ch_rdy, mix_out, mix_vld, overrun
    );

    modport slave (
        input  ch_data, ch_vld, ch_mask, mix_rdy, ovr_clr,
        output ch_rdy, mix_out, mix_vld, overrun
    );
endinterface
`default_nettype wire

// File: rtl/bytebeat_sample_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : bytebeat_sample_mixer
//  Brief    : Averages the enabled PCM channels once per sample period.
//  Revision : 1.0 - initial release
// ============================================================================
module bytebeat_sample_mixer #(
    parameter int N_CH     = 8,
    parameter int W        = 8,
    parameter int TICK_DIV = 256
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bytebeat_sample_mixer_if.slave  bus
);

    localparam int IW  = $clog2(N_CH);
    localparam int CW  = IW + 1;
    localparam int SW  = W + IW;
    localparam int STW = $clog2(SW);
    localparam int TW  = $clog2(TICK_DIV);

    localparam logic [W-1:0]   c_MID      = {1'b1, {(W-1){1'b0}}};
    localparam logic [TW-1:0]  c_TICK_END = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0]  c_IDX_LAST = IW'(N_CH - 1);
    localparam logic [STW-1:0] c_STEP_END = STW'(SW - 1);
    localparam logic [CW-1:0]  c_CNT_ONE  = CW'(1);
    localparam logic [IW-1:0]  c_IDX_ONE  = IW'(1);
    localparam logic [STW-1:0] c_STEP_ONE = STW'(1);
    localparam logic [TW-1:0]  c_TICK_ONE = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;

    logic [W-1:0]    r_hold [N_CH];
    logic            w_rdy;

    logic [N_CH-1:0] r_mask;
    logic [SW-1:0]   r_sum;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_rem;
    logic [STW-1:0]  r_step;

    logic [W-1:0]    w_hold_sel;
    logic [CW:0]     w_trial;
    logic            w_ge;
    logic [CW-1:0]   w_rem_nxt;

    logic [W-1:0]    r_mix_out;
    logic            r_mix_vld;
    logic            r_overrun;
    logic            w_ovr_set;

    // ------------------------------------------------------------------
    // Sample-period tick
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_TICK_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel holding registers; only refreshed while IDLE so the
    // accumulation sees a stable snapshot
    // ------------------------------------------------------------------
    assign w_rdy = (r_state == S_IDLE) && rst_n;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_hold
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold[gi] <= c_MID;
                end else if (bus.ch_vld[gi] && w_rdy) begin
                    r_hold[gi] <= bus.ch_data[gi*W +: W];
                end
            end
            assign bus.ch_rdy[gi] = w_rdy;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick)                 w_state_nxt = S_ACCUM;
            S_ACCUM: if (r_idx == c_IDX_LAST)    w_state_nxt = S_DIV;
            S_DIV:   if (r_step == c_STEP_END)   w_state_nxt = S_DONE;
            S_DONE:                              w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divider step: r_sum shifts the dividend out and the
    // quotient in, one bit per cycle
    // ------------------------------------------------------------------
    assign w_hold_sel = r_hold[r_idx];
    assign w_trial    = {r_rem, r_sum[SW-1]};
    assign w_ge       = (w_trial >= {1'b0, r_cnt});
    assign w_rem_nxt  = w_ge ? CW'(w_trial - {1'b0, r_cnt}) : w_trial[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_rem  <= '0;
            r_step <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_mask <= bus.ch_mask;
                        r_sum  <= '0;
                        r_cnt  <= '0;
                        r_idx  <= '0;
                        r_rem  <= '0;
                    end
                end
                S_ACCUM: begin
                    if (r_mask[r_idx]) begin
                        r_sum <= r_sum + SW'(w_hold_sel);
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    r_idx  <= r_idx + c_IDX_ONE;
                    r_step <= '0;
                end
                S_DIV: begin
                    r_sum  <= {r_sum[SW-2:0], w_ge};
                    r_rem  <= w_rem_nxt;
                    r_step <= r_step + c_STEP_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output handshake and overrun flag
    // ------------------------------------------------------------------
    assign w_ovr_set = (r_state == S_DONE) && r_mix_vld && !bus.mix_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mix_out <= c_MID;
            r_mix_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                // an empty mask yields midscale silence instead of the x/0 result
                r_mix_out <= (r_cnt == '0) ? c_MID : r_sum[W-1:0];
                r_mix_vld <= 1'b1;
            end else if (bus.mix_rdy) begin
                r_mix_vld <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.mix_out = r_mix_out;
    assign bus.mix_vld = r_mix_vld;
    assign bus.overrun = r_overrun;

    a_tick_only_in_idle : assert property (
        @(posedge clk) disable iff (!rst_n) w_tick |-> (r_state == S_IDLE)
    );

endmodule
`default_nettype wire

// File: tb/tb_bytebeat_sample_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bytebeat_sample_mixer
//  Brief    : Directed + randomized bench against a frame-level mixer model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bytebeat_sample_mixer;

    localparam int N_CH = 8;
    localparam int W    = 8;
    localparam int TD   = 32;
    localparam int SW   = W + $clog2(N_CH);
    localparam int LAT  = N_CH + SW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bytebeat_sample_mixer_if #(.N_CH(N_CH), .W(W)) bus ();

    bytebeat_sample_mixer #(.N_CH(N_CH), .W(W), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Frame-level model: n counts clock edges since reset release
    int          n = 0;
    int          hold_m [N_CH];
    int          due   = -1;
    int          due_val;
    logic [W-1:0] m_out = 8'h80;
    bit          m_vld  = 1'b0;
    bit          m_ovr  = 1'b0;
    bit          set_ovr;
    int          acc, cnt_en;

    function automatic bit busy(input int c);
        return (c >= TD) && ((c % TD) <= LAT - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            for (int i = 0; i < N_CH; i++) hold_m[i] = 'h80;
            due   = -1;
            m_out = 8'h80;
            m_vld = 1'b0;
            m_ovr = 1'b0;
        end else begin
            if (!busy(n)) begin
                for (int i = 0; i < N_CH; i++)
                    if (bus.ch_vld[i]) hold_m[i] = int'(bus.ch_data[i*W +: W]);
            end
            if ((n % TD) == TD - 1) begin
                acc = 0;
                cnt_en = 0;
                for (int i = 0; i < N_CH; i++)
                    if (bus.ch_mask[i]) begin
                        acc += hold_m[i];
                        cnt_en++;
                    end
                due_val = (cnt_en == 0) ? 'h80 : acc / cnt_en;
                due     = n + LAT;
            end
            set_ovr = 1'b0;
            if (due == n) begin
                set_ovr = m_vld && !bus.mix_rdy;
                m_vld   = 1'b1;
                m_out   = due_val[W-1:0];
                due     = -1;
            end else if (bus.mix_rdy) begin
                m_vld = 1'b0;
            end
            if (set_ovr)           m_ovr = 1'b1;
            else if (bus.ovr_clr)  m_ovr = 1'b0;
            n++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    logic [N_CH-1:0] exp_rdy;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_rdy = (rst_n && !busy(n)) ? '1 : '0;
            chk("model_ch_rdy",  bus.ch_rdy,  exp_rdy);
            chk("model_mix_out", bus.mix_out, m_out);
            chk("model_mix_vld", bus.mix_vld, m_vld);
            chk("model_overrun", bus.overrun, m_ovr);
        end
    end

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (n < k && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n != k) begin
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", n, k);
        end
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] v);
        bus.ch_data[ch*W +: W] = v;
    endtask

    initial begin
        bus.ch_data = '0;
        bus.ch_vld  = '0;
        bus.ch_mask = '0;
        bus.mix_rdy = 1'b0;
        bus.ovr_clr = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mix_out", bus.mix_out, 8'h80);
        chk("rst_mix_vld", bus.mix_vld, 1'b0);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_ch_rdy",  bus.ch_rdy,  8'h00);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // 1: empty mask gives midscale, exactly LAT cycles after the tick
        wait_cyc(TD - 1 + LAT);
        chk("t1_not_early", bus.mix_vld, 1'b0);
        wait_cyc(TD + LAT);
        chk("t1_mix_out", bus.mix_out, 8'h80);
        chk("t1_mix_vld", bus.mix_vld, 1'b1);
        chk("t1_overrun", bus.overrun, 1'b0);
        bus.mix_rdy = 1'b1;

        // 2: (0x40 + 0x81) / 2 = 0x60
        wait_cyc(55);
        set_ch(0, 8'h40);
        set_ch(1, 8'h81);
        bus.ch_vld  = 8'h03;
        bus.ch_mask = 8'h03;
        wait_cyc(56);
        bus.ch_vld = '0;
        wait_cyc(83);
        chk("t2_before_out", bus.mix_out, 8'h80);
        chk("t2_before_vld", bus.mix_vld, 1'b0);
        wait_cyc(84);
        chk("t2_mix_out", bus.mix_out, 8'h60);
        chk("t2_mix_vld", bus.mix_vld, 1'b1);

        // 3: full scale, then zero
        wait_cyc(90);
        bus.ch_data = '1;
        bus.ch_vld  = '1;
        bus.ch_mask = 8'hFF;
        wait_cyc(91);
        bus.ch_vld = '0;
        wait_cyc(116);
        chk("t3_full", bus.mix_out, 8'hFF);
        wait_cyc(120);
        bus.ch_data = '0;
        bus.ch_vld  = '1;
        wait_cyc(121);
        bus.ch_vld = '0;
        wait_cyc(148);
        chk("t3_zero", bus.mix_out, 8'h00);

        // 4: 2/3 truncates to 0; samples offered while busy are refused
        wait_cyc(152);
        chk("t4_rdy_idle", bus.ch_rdy, 8'hFF);
        set_ch(0, 8'h01);
        set_ch(1, 8'h01);
        set_ch(2, 8'h00);
        bus.ch_vld  = 8'h07;
        bus.ch_mask = 8'h07;
        wait_cyc(153);
        bus.ch_vld = '0;
        wait_cyc(165);
        chk("t4_rdy_busy", bus.ch_rdy, 8'h00);
        bus.ch_data = {N_CH{8'hAA}};
        bus.ch_vld  = '1;
        wait_cyc(166);
        bus.ch_vld = '0;
        wait_cyc(180);
        chk("t4_trunc", bus.mix_out, 8'h00);
        wait_cyc(212);
        chk("t4_no_accept", bus.mix_out, 8'h00);

        // 5: two unconsumed frames raise overrun; ovr_clr drops it
        wait_cyc(213);
        bus.mix_rdy = 1'b0;
        wait_cyc(215);
        set_ch(0, 8'h33);
        bus.ch_vld  = 8'h01;
        bus.ch_mask = 8'h01;
        wait_cyc(216);
        bus.ch_vld = '0;
        wait_cyc(244);
        chk("t5_first_out", bus.mix_out, 8'h33);
        chk("t5_first_ovr", bus.overrun, 1'b0);
        wait_cyc(246);
        set_ch(0, 8'h44);
        bus.ch_vld = 8'h01;
        wait_cyc(247);
        bus.ch_vld = '0;
        wait_cyc(276);
        chk("t5_second_out", bus.mix_out, 8'h44);
        chk("t5_overrun",    bus.overrun, 1'b1);
        chk("t5_vld_held",   bus.mix_vld, 1'b1);
        wait_cyc(278);
        bus.ovr_clr = 1'b1;
        wait_cyc(279);
        bus.ovr_clr = 1'b0;
        chk("t5_ovr_cleared", bus.overrun, 1'b0);

        // 6: asynchronous reset while dividing, then a clean restart
        wait_cyc(300);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_out", bus.mix_out, 8'h80);
        chk("t6_async_vld", bus.mix_vld, 1'b0);
        chk("t6_async_rdy", bus.ch_rdy,  8'h00);
        repeat (3) @(negedge clk);
        rst_n       = 1'b1;
        bus.mix_rdy = 1'b1;
        bus.ch_mask = 8'h03;
        wait_cyc(TD - 1 + LAT);
        chk("t6_restart_early", bus.mix_vld, 1'b0);
        wait_cyc(TD + LAT);
        chk("t6_restart_vld", bus.mix_vld, 1'b1);
        chk("t6_restart_out", bus.mix_out, 8'h80);

        // Randomized traffic, checked every cycle by the model
        repeat (150 * TD) begin
            @(negedge clk);
            for (int i = 0; i < N_CH; i++)
                bus.ch_data[i*W +: W] = W'($urandom_range(0, 255));
            bus.ch_vld  = N_CH'($urandom);
            bus.ch_mask = ($urandom_range(0, 7) == 0) ? '0 : N_CH'($urandom);
            bus.mix_rdy = ($urandom_range(0, 2) == 0);
            bus.ovr_clr = ($urandom_range(0, 15) == 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
